// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit slices.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

endpackage

// File: rtl/bcd_digit_down.sv
// Combinational single-digit BCD decrement with borrow chaining.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t next_digit,
  output logic       borrow_out
);

  // A zero digit wraps to 9 and passes the borrow upward.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: load/start/stop control, one decrement per tick,
// one-cycle done pulse on expiry and a load_err pulse when a preset digit is out of range.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  input  logic                tick,
  output logic [4*DIGITS-1:0] q,
  output logic                running,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  timer_state_t   state, state_next;
  logic [W-1:0]   q_reg, q_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;

  logic [W-1:0]   q_dec;
  logic [DIGITS:0] borrow;
  logic [W-1:0]   sanitized;
  logic           bad_digit;

  assign borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_digit_down u_digit (
        .digit      (q_reg[4*g +: 4]),
        .borrow_in  (borrow[g]),
        .next_digit (q_dec[4*g +: 4]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // Out-of-range preset digits are clamped to 9 and flagged.
  always_comb begin
    sanitized = '0;
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX) begin
        sanitized[4*i +: 4] = BCD_MAX;
        bad_digit           = 1'b1;
      end else begin
        sanitized[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_reg    <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      q_reg    <= q_next;
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (load) begin
      q_next     = sanitized;
      state_next = IDLE;
      err_next   = bad_digit;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (q_reg == '0) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_next = PAUSED;
          end else if (tick) begin
            // A borrow out of the top digit would mean underflow; clamp to zero instead.
            if (q_dec == '0 || borrow[DIGITS]) begin
              q_next     = '0;
              state_next = EXPIRED;
              done_next  = 1'b1;
            end else begin
              q_next = q_dec;
            end
          end
        end
        PAUSED: begin
          if (start) state_next = RUN;
        end
        EXPIRED: begin
          q_next = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    q        = q_reg;
    running  = (state == RUN);
    done     = done_reg;
    load_err = err_reg;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized self-checking bench for bcd_countdown_timer against an integer-valued
// reference model of the countdown rules.
module tb_bcd_countdown_timer;

  localparam int D = 4;
  localparam int W = 4 * D;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_EXPIRED = 3;

  logic         clk = 1'b0;
  logic         reset, load, start, stop, tick;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         running, done, load_err;

  int vectors     = 0;
  int miscompares = 0;

  int m_val;
  int m_state;
  bit m_done;
  bit m_err;

  bcd_countdown_timer #(.DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .q        (q),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] toBcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour expressed on the count as a plain integer.
  task automatic modelStep(input bit r, input bit ld, input logic [W-1:0] lv,
                           input bit st, input bit sp, input bit tk);
    int v, pw, dg;
    bit bad;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_val   = 0;
      m_state = M_IDLE;
    end else if (ld) begin
      v   = 0;
      pw  = 1;
      bad = 1'b0;
      for (int i = 0; i < D; i++) begin
        dg = int'(lv[4*i +: 4]);
        if (dg > 9) begin
          dg  = 9;
          bad = 1'b1;
        end
        v  = v + dg * pw;
        pw = pw * 10;
      end
      m_val   = v;
      m_state = M_IDLE;
      m_err   = bad;
    end else begin
      case (m_state)
        M_IDLE: if (st) begin
          if (m_val == 0) begin
            m_state = M_EXPIRED;
            m_done  = 1'b1;
          end else begin
            m_state = M_RUN;
          end
        end
        M_RUN: if (sp) begin
          m_state = M_PAUSED;
        end else if (tk) begin
          m_val = m_val - 1;
          if (m_val == 0) begin
            m_state = M_EXPIRED;
            m_done  = 1'b1;
          end
        end
        M_PAUSED: if (st) m_state = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ld, input logic [W-1:0] lv,
                               input bit st, input bit sp, input bit tk);
    reset    = r;
    load     = ld;
    load_val = lv;
    start    = st;
    stop     = sp;
    tick     = tk;
    @(posedge clk);
    modelStep(r, ld, lv, st, sp, tk);
    #1;
    checkOutput("q",        32'(q),        32'(toBcd(m_val)));
    checkOutput("running",  32'(running),  32'(m_state == M_RUN));
    checkOutput("done",     32'(done),     32'(m_done));
    checkOutput("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    m_val   = 0;
    m_state = M_IDLE;
    m_done  = 1'b0;
    m_err   = 1'b0;
    applyStimulus(1, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0, 0);
    checkOutput("reset_q", 32'(q), 32'h0);

    $display("[TB] directed: decrement and borrow");
    applyStimulus(0, 1, 16'h0102, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);
    checkOutput("plan_q_0099", 32'(q), 32'h0099);

    applyStimulus(0, 1, 16'h1000, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    checkOutput("plan_q_0999", 32'(q), 32'h0999);

    $display("[TB] directed: expiry");
    applyStimulus(0, 1, 16'h0003, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);
    checkOutput("plan_expire_done", 32'(done), 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 1, 0, 0);
    checkOutput("plan_expired_done_low", 32'(done), 32'h0);

    $display("[TB] directed: pause");
    applyStimulus(0, 1, 16'h0050, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0, 0, 1);
    checkOutput("plan_paused_q", 32'(q), 32'h0049);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    checkOutput("plan_resumed_q", 32'(q), 32'h0048);

    $display("[TB] directed: bad load");
    applyStimulus(0, 1, 16'h1A0F, 0, 0, 0);
    checkOutput("plan_sanitized_q", 32'(q), 32'h1909);
    applyStimulus(0, 1, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    checkOutput("plan_zero_start_done", 32'(done), 32'h1);

    $display("[TB] directed: reset mid-run");
    applyStimulus(0, 1, 16'h0020, 0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(1, 0, '0, 0, 0, 1);
    checkOutput("plan_reset_running", 32'(running), 32'h0);
    applyStimulus(0, 0, '0, 1, 0, 0);
    idle(2);

    $display("[TB] random stimulus");
    for (int n = 0; n < 3000; n++) begin
      bit           r, ld, st, sp, tk;
      logic [W-1:0] lv;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) lv = W'($urandom_range(0, 40));
      else                           lv = W'($urandom);
      applyStimulus(r, ld, lv, st, sp, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the team's 0-9 decade up-counter.
- Loaded with a BCD preset, started and paused by control pulses, decremented once per qualified tick.
- Signals expiry with a one-cycle done pulse.
- Sits beside the display/BCD counter logic; drives 7-seg decoders and timeout consumers.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); counter width is 4*DIGITS bits.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high; clock clk.
- load, input, 1, load load_val into q; returns to IDLE.
- load_val, input, 4*DIGITS, BCD preset; digit i at bits [4i+3:4i].
- start, input, 1, start or resume countdown.
- stop, input, 1, pause countdown.
- tick, input, 1, count-enable strobe; one decrement per cycle when high in RUN.
- q, output, 4*DIGITS, current BCD count (registered).
- running, output, 1, high while state is RUN (registered).
- done, output, 1, one-cycle pulse when count reaches zero.
- load_err, output, 1, one-cycle pulse when a load contained a digit >9.

Behaviour:
- Reset: state IDLE, q=0, running=0, done=0, load_err=0.
- Priority in any cycle: reset > load > start/stop > tick.
- States: IDLE, RUN, PAUSED, EXPIRED. running = (state==RUN), registered.
- All outputs change on the clock edge that samples the input: one-cycle latency, no combinational paths to outputs.
- load (any state except reset):
  - q <= sanitized load_val, state <= IDLE, done <= 0.
  - Sanitize: any digit >9 is loaded as 9, and load_err pulses high for one cycle.
  - Concurrent start/stop/tick are ignored.
- IDLE:
  - start with q!=0 -> RUN.
  - start with q==0 -> EXPIRED, done pulses.
  - stop and tick are ignored.
- RUN:
  - stop -> PAUSED; a tick in the same cycle is ignored (stop wins).
  - start is a no-op.
  - tick alone: q decrements by 1 in BCD.
    - Digit 0 is decremented.
    - A digit at 0 wraps to 9 and borrows from the next digit.
    - Borrow ripples through all digits within the same cycle.
  - tick with q==1 (least-significant digit 1, all others 0): q <= 0, done pulses one cycle, state -> EXPIRED, running drops in the same edge.
  - q==0 is unreachable in RUN; never underflow to all-9s.
- PAUSED:
  - start -> RUN.
  - tick is ignored; q is held.
  - stop is a no-op.
- EXPIRED:
  - q held at 0; tick, start and stop are ignored.
  - Only load or reset leaves EXPIRED.
- done is high for exactly one cycle per expiry; never asserted while q!=0.
- start and stop in the same cycle: stop wins in RUN; start wins in PAUSED/IDLE.
- reset mid-RUN clears q immediately on that edge; no done pulse.
- Width: q is 4*DIGITS bits; every digit of q is always in 0..9.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9.
  - State enum timer_state_t {IDLE, RUN, PAUSED, EXPIRED}.
  - A BCD-digit typedef (4-bit).
- Sub-module bcd_digit_down: combinational single-digit decrement.
  - Inputs: digit[3:0], borrow_in.
  - Outputs: next_digit[3:0], borrow_out (high when digit==0 and borrow_in).
  - DIGITS copies are chained via generate.
- The top level holds the FSM, the q register, and the load sanitizer.

Test Plan (DIGITS=4, q shown as hex BCD):
- Decrement and borrow: load 0x0102, start, 3 ticks -> q 0x0101, 0x0100, 0x0099; running=1 throughout; done=0.
- Multi-digit borrow: load 0x1000, start, 1 tick -> q 0x0999.
- Expiry: load 0x0003, start, 3 ticks -> q 0x0000; done high exactly one cycle on the 3rd tick edge; running=0; a further 5 ticks and a start leave q=0, done=0.
- Pause: load 0x0050, start, tick (q=0x0049), then stop+tick in the same cycle -> q stays 0x0049, state PAUSED; 4 ticks -> q unchanged; start, tick -> 0x0048.
- Bad load: load 0x1A0F -> q 0x1909, load_err one-cycle pulse; load 0x0000 then start -> done pulse next edge, running never high.
- Reset mid-run: load 0x0020, start, 2 ticks, assert reset with tick -> q 0x0000, running=0, done=0; start afterwards -> EXPIRED with a done pulse.
